// File: rtl/shares_words_serializer.sv
// Parallel-to-serial transmitter for masked values: d shares x up to MAX_WORDS_PER_SHARE words, share-major order.
// Optional macro SHARES_SERIALIZER_CLEAR_EN: zero the buffer on reset and after the last word, force out_data=0 in IDLE.
module shares_words_serializer #(
  parameter int W                   = 32,
  parameter int MAX_WORDS_PER_SHARE = 8,
  parameter int d                   = 2,
  parameter int NBITS               = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [d*MAX_WORDS_PER_SHARE*W-1:0] in_data,
  input  logic [NBITS-1:0]                   in_bound,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [W-1:0]                       out_data,
  output logic                               out_last,
  output logic [NBITS-1:0]                   out_share_idx,
  output logic [NBITS-1:0]                   out_word_idx
);

  localparam int               BUF_W      = d * MAX_WORDS_PER_SHARE * W;
  localparam logic [NBITS-1:0] BOUND_MAX  = NBITS'(MAX_WORDS_PER_SHARE - 1);
  localparam logic [NBITS-1:0] SHARE_LAST = NBITS'(d - 1);
  localparam logic [NBITS-1:0] ONE        = NBITS'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [NBITS-1:0] bound_q, bound_d;
  logic [NBITS-1:0] share_cnt_q, share_cnt_d;
  logic [NBITS-1:0] word_cnt_q, word_cnt_d;
  logic             word_end;
  logic             last_word;
  logic [W-1:0]     word_sel;

  // Saturate the runtime bound to the buffer depth instead of letting it wrap.
  function automatic logic [NBITS-1:0] clamp_bound(input logic [NBITS-1:0] b);
    return (b > BOUND_MAX) ? BOUND_MAX : b;
  endfunction

  assign word_end  = (word_cnt_q == bound_q);
  assign last_word = (state_q == SEND) && (share_cnt_q == SHARE_LAST) && word_end;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    bound_d     = bound_q;
    share_cnt_d = share_cnt_q;
    word_cnt_d  = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = SEND;
          buf_d       = in_data;
          bound_d     = clamp_bound(in_bound);
          share_cnt_d = '0;
          word_cnt_d  = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_word) begin
            state_d     = IDLE;
            share_cnt_d = '0;
            word_cnt_d  = '0;
`ifdef SHARES_SERIALIZER_CLEAR_EN
            buf_d       = '0;
`endif
          end else if (word_end) begin
            word_cnt_d  = '0;
            share_cnt_d = share_cnt_q + ONE;
          end else begin
            word_cnt_d  = word_cnt_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bound_q     <= '0;
      share_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bound_q     <= bound_d;
      share_cnt_q <= share_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Share material is only scrubbed when the clearing option is built in.
`ifdef SHARES_SERIALIZER_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) buf_q <= '0;
    else     buf_q <= buf_d;
  end
`else
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end
`endif

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < MAX_WORDS_PER_SHARE; j++) begin
        if (share_cnt_q == NBITS'(i) && word_cnt_q == NBITS'(j))
          word_sel = buf_q[(i*MAX_WORDS_PER_SHARE+j)*W +: W];
      end
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == SEND);
  assign out_last      = last_word;
  assign out_share_idx = share_cnt_q;
  assign out_word_idx  = word_cnt_q;
`ifdef SHARES_SERIALIZER_CLEAR_EN
  assign out_data      = (state_q == SEND) ? word_sel : '0;
`else
  assign out_data      = word_sel;
`endif

endmodule

// File: tb/tb_shares_words_serializer.sv
// Bench for shares_words_serializer: fixed vector table, hand-written corner sequences, randomized values vs. a queue model.
`timescale 1ns/1ps
module tb_shares_words_serializer;
  localparam int W    = 32;
  localparam int MAXW = 8;
  localparam int D    = 2;
  localparam int NB   = 4;
  localparam int TOT  = D * MAXW * W;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [TOT-1:0] in_data;
  logic [NB-1:0]  in_bound;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [NB-1:0]  out_share_idx;
  logic [NB-1:0]  out_word_idx;

  shares_words_serializer #(.W(W), .MAX_WORDS_PER_SHARE(MAXW), .d(D), .NBITS(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bound(in_bound),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_share_idx(out_share_idx), .out_word_idx(out_word_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    int           s;
    int           w;
    logic         last;
  } exp_t;

  typedef struct {
    logic [NB-1:0] bnd;
    int            mode;
    int            beats;
    logic [W-1:0]  last_word;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TOT-1:0] pat(input logic [31:0] base);
    logic [TOT-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < MAXW; j++)
        v[(i*MAXW+j)*W +: W] = base + 32'(16*i + j);
    return v;
  endfunction

  function automatic logic [TOT-1:0] rand_value();
    logic [TOT-1:0] v;
    for (int k = 0; k < TOT/32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Load one value and drain it; mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic run_value(input logic [TOT-1:0] data, input logic [NB-1:0] bnd, input int mode,
                           input string tag, output int beats, output logic [W-1:0] last_w);
    exp_t q[$];
    int   eb, guard, cyc;
    logic rdy;
    eb = (int'(bnd) > MAXW-1) ? MAXW-1 : int'(bnd);
    for (int s = 0; s < D; s++)
      for (int w = 0; w <= eb; w++)
        q.push_back('{data[(s*MAXW+w)*W +: W], s, w, (s == D-1) && (w == eb)});
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk({tag, "_load_wait"}, {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = data; in_bound = bnd;
    @(negedge clk);
    in_valid = 1'b0; in_data = rand_value(); in_bound = NB'($urandom());
    chk({tag, "_latency_valid"}, {63'd0, out_valid}, 64'd1);
    beats = 0; cyc = 0; last_w = '0;
    while (cyc < 1000 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk({tag, "_extra_beat"}, 64'd1, 64'd0);
        break;
      end
      chk($sformatf("%s_data_%0d", tag, beats), {32'd0, out_data}, {32'd0, q[0].word});
      chk($sformatf("%s_share_%0d", tag, beats), {60'd0, out_share_idx}, 64'(q[0].s));
      chk($sformatf("%s_word_%0d", tag, beats), {60'd0, out_word_idx}, 64'(q[0].w));
      chk($sformatf("%s_last_%0d", tag, beats), {63'd0, out_last}, {63'd0, q[0].last});
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(1) == 1);
      endcase
      out_ready = rdy;
      if (rdy) begin last_w = out_data; beats++; end
      @(negedge clk);
      cyc++;
      if (rdy) void'(q.pop_front());
    end
    out_ready = 1'b0;
    chk({tag, "_missing_beats"}, 64'(q.size()), 64'd0);
    chk({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
`ifdef SHARES_SERIALIZER_CLEAR_EN
    chk({tag, "_idle_data_clear"}, {32'd0, out_data}, 64'd0);
`endif
    if (out_valid === 1'b1) do_reset();
  endtask

  vec_t         vt[6];
  int           beats;
  logic [W-1:0] lw;
  logic [TOT-1:0] va, vb;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'd3,  0, 8,  32'hA000_0013};
    vt[1] = '{4'd3,  1, 8,  32'hA000_0013};
    vt[2] = '{4'd0,  0, 2,  32'hA000_0010};
    vt[3] = '{4'd15, 0, 16, 32'hA000_0017};
    vt[4] = '{4'd8,  2, 16, 32'hA000_0017};
    vt[5] = '{4'd1,  1, 4,  32'hA000_0011};
    va = pat(32'hA000_0000);
    vb = pat(32'hB000_0000);
    in_data = '0; in_bound = '0;
    do_reset();

    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_share_idx", {60'd0, out_share_idx}, 64'd0);
    chk("rst_word_idx", {60'd0, out_word_idx}, 64'd0);
`ifdef SHARES_SERIALIZER_CLEAR_EN
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
`endif

    for (int i = 0; i < 6; i++) begin
      run_value(va, vt[i].bnd, vt[i].mode, $sformatf("vec%0d", i), beats, lw);
      chk($sformatf("vec%0d_beats", i), 64'(beats), 64'(vt[i].beats));
      chk($sformatf("vec%0d_last_word", i), {32'd0, lw}, {32'd0, vt[i].last_word});
    end

    // in_valid held high across a whole value: B offered during SEND must be ignored, then load after one bubble.
    in_valid = 1'b1; in_data = va; in_bound = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    in_data = vb; in_bound = 4'd1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("hold_a_data_%0d", k), {32'd0, out_data}, {32'd0, 32'hA000_0000 + 32'(16*(k/4) + k%4)});
      @(negedge clk);
    end
    chk("hold_bubble_valid", {63'd0, out_valid}, 64'd0);
    chk("hold_bubble_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold_b_valid_%0d", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("hold_b_data_%0d", k), {32'd0, out_data}, {32'd0, 32'hB000_0000 + 32'(16*(k/2) + k%2)});
      @(negedge clk);
    end
    chk("hold_b_done", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;

    // Reset after the third beat drops the pending value.
    in_valid = 1'b1; in_data = va; in_bound = 4'd3;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_share_idx", {60'd0, out_share_idx}, 64'd0);
    chk("midrst_word_idx", {60'd0, out_word_idx}, 64'd0);
    chk("midrst_out_last", {63'd0, out_last}, 64'd0);
`ifdef SHARES_SERIALIZER_CLEAR_EN
    chk("midrst_out_data", {32'd0, out_data}, 64'd0);
`endif
    run_value(vb, 4'd2, 0, "after_rst", beats, lw);
    chk("after_rst_beats", 64'(beats), 64'd6);
    chk("after_rst_last_word", {32'd0, lw}, {32'd0, 32'hB000_0012});

    for (int r = 0; r < 25; r++) begin
      run_value(rand_value(), NB'($urandom_range(15)), $urandom_range(2), $sformatf("rnd%0d", r), beats, lw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/shares_words_serializer.md
# shares_words_serializer

Transmit-side counterpart of the serial share/word receive path. Accepts one full masked value of `d` shares × up to `MAX_WORDS_PER_SHARE` words in parallel. Emits it one `W`-bit word per accepted beat over a valid/ready stream, in share-major order (all words of share 0, then share 1, …). Sits between the masked core output and the serial bus; the downstream deserializer reconstructs the value with the same runtime words-per-share bound.

## Interface
- `W`, 32, word width in bits
- `MAX_WORDS_PER_SHARE`, 8, buffer capacity per share in words
- `d`, 2, number of shares (≥1)
- `NBITS`, 4, width of bound and index fields; requires 2^NBITS > max(d, MAX_WORDS_PER_SHARE)

- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  parallel value offered
- `in_ready`  out  1  serializer can load
- `in_data`  in  `d*MAX_WORDS_PER_SHARE*W`  share i word j at bits `[(i*MAX_WORDS_PER_SHARE+j)*W +: W]`
- `in_bound`  in  NBITS  words per share minus 1, sampled at load
- `out_valid`  out  1  word presented
- `out_ready`  in  1  sink accepts word
- `out_data`  out  W  current word
- `out_last`  out  1  current word is last word of last share
- `out_share_idx`  out  NBITS  share index of current word
- `out_word_idx`  out  NBITS  word index within share of current word

## Operation
- FSM: IDLE, SEND.
- IDLE:
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid`: latch `in_data` into the buffer and the bound into `bound_q`; clear both counters; go to SEND.
- Bound latching:
  - `bound_q = min(in_bound, MAX_WORDS_PER_SHARE-1)`.
  - Out-of-range values clamp; never wrap.
- SEND:
  - `in_ready=0`, `out_valid=1`.
  - `out_data` = buffer word (`share_cnt`, `word_cnt`).
  - `out_last = (share_cnt==d-1) && (word_cnt==bound_q)`.
- Transfer = `out_valid & out_ready`. On a transfer:
  - If `word_cnt==bound_q`: `word_cnt←0`, `share_cnt←share_cnt+1`.
  - Otherwise: `word_cnt←word_cnt+1`.
  - If `out_last`: go to IDLE; counters return to 0.
- No transfer: all outputs and state hold (AXI-stream style; `out_valid` never drops once raised until transfer).
- Beats per value: exactly `d*(bound_q+1)`. Words with index > `bound_q` are never emitted.
- `out_share_idx=share_cnt`, `out_word_idx=word_cnt`. Counters use NBITS-bit unsigned arithmetic. `share_cnt` never exceeds d-1; `word_cnt` never exceeds `bound_q`.
- No load is accepted during SEND. `in_data`/`in_bound` changes during SEND are ignored.
- Reset mid-operation: FSM→IDLE, counters→0, `out_valid=0`. The pending value is dropped, not resumed.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_last=0`
  - `out_share_idx=0`, `out_word_idx=0`
  - `out_data`: 0 with the Configuration macro defined; otherwise don't-care
- Load latency: handshake at edge k → `out_valid=1` with word (0,0) from cycle k+1.
- Throughput: one word per cycle while `out_ready=1`.
- The final transfer at edge m returns to IDLE. `in_ready=1` in cycle m+1, so the next word (0,0) appears at m+2 at earliest: one bubble between values.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration
- `SHARES_SERIALIZER_CLEAR_EN` defined:
  - The whole buffer is zeroed on `rst` and on the final transfer (`out_last` handshake).
  - `out_data=0` whenever in IDLE, so no share material remains after transmission.
- Undefined: the buffer keeps the last loaded value; only `out_valid` qualifies `out_data`. This costs less area.

## Test plan
- d=2, W=32, MAX=8, `in_bound=3`, share i word j = `0xA000_0000+16*i+j`, `out_ready=1` → 8 beats: A0000000..A0000003, then A0000010..A0000013. `out_last` only on beat 8; indices (0,0)…(1,3); `in_ready` back to 1 one cycle after beat 8.
- Same value with `out_ready` toggling 1,0,0,1,… → identical word sequence. `out_data`/`out_last`/indices stable during every stall cycle.
- `in_bound=0` → 2 beats: A0000000, A0000010. `in_bound=15` clamps to 7 → 16 beats, last is A0000017.
- `in_valid` held high through a block with new data → second load occurs only in IDLE. Exactly one bubble between A0000013 and the next (0,0) word.
- `rst` asserted after beat 3 → next cycle `out_valid=0`, `in_ready=1`, indices 0. With `SHARES_SERIALIZER_CLEAR_EN`: `out_data=0`. A new load restarts at word (0,0).
- With `SHARES_SERIALIZER_CLEAR_EN`: after beat 8, `out_data=0` in IDLE. Without it, `out_data` keeps its old value but `out_valid=0`.
